uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
- Transmit sequencer for the UART TX path. It accepts parallel bytes over a valid/ready handshake and gates the shared baud-rate generator through baud_en.
- It advances start/data/parity/stop bits on each 1x baud_tick and drives the serial line.
- It sits between the host-side byte source and the tx pin. The baud generator is the only timing source.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..9.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 even, 1 odd.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- tx_data  in  DATA_BITS  byte to send; sampled only on accept
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  controller can accept; transfer occurs when tx_valid && tx_ready at posedge clk
- baud_en  out  1  enable to the baud-rate generator
- baud_tick  in  1  1x bit-period pulse from the generator, one clk wide
- tx  out  1  serial line, idle high
- busy  out  1  frame in progress (state != IDLE)
- frame_done  out  1  one-cycle pulse on the final stop-bit boundary

Behaviour:
- Reset (async, any state): state=IDLE, tx=1, baud_en=0, busy=0, frame_done=0, bit counter=0, shift register=0. A reset mid-frame aborts the frame; tx returns high immediately and no partial bits resume.
- Registered outputs: tx, baud_en, busy, frame_done. tx_ready is combinational: 1 in IDLE, and 1 in STOP when baud_tick=1 and the current stop bit is the last one. Otherwise 0.
- States: IDLE, START, DATA, PARITY, STOP. Every transition out of START/DATA/PARITY/STOP occurs only on an edge where baud_tick is sampled 1.
- IDLE:
  - baud_tick is ignored.
  - On accept: capture tx_data into the shift register, compute parity, then tx<=0, baud_en<=1, busy<=1, go to START.
- START: on tick, tx<=shift[0], shift right, count=0, go to DATA.
- DATA:
  - Bits go LSB first.
  - On tick with count<DATA_BITS-1: tx<=next bit, count++.
  - On tick with count==DATA_BITS-1: go to PARITY (tx<=parity) if PARITY_EN, else go to STOP (tx<=1).
- Parity value: XOR of the captured data bits, XOR PARITY_ODD.
- PARITY: on tick, tx<=1, go to STOP.
- STOP: tx=1 held for STOP_BITS tick periods. On the final stop tick, frame_done<=1 for one cycle, then:
  - If tx_valid=1 (back-to-back): accept the new byte, tx<=0, stay enabled, go to START. baud_en stays 1 with no deassert cycle, so generator phase is preserved.
  - Else: baud_en<=0, busy<=0, go to IDLE.
- Bit timing: each bit spans the interval between consecutive sampled ticks. The first (start) bit additionally includes the generator startup latency after baud_en rises.
- tx_data/tx_valid changes while busy have no effect on the frame in flight.
- A baud_tick and tx_valid arriving in the same cycle in IDLE: the accept happens and the tick is ignored.
- Frame length in ticks: 1 + DATA_BITS + PARITY_EN + STOP_BITS.

Test Plan:
- Reset with tx_valid=0 -> tx=1, baud_en=0, busy=0, tx_ready=1; baud_tick pulses in IDLE leave every output unchanged.
- 8N1, send 0xA3, bench drives baud_tick every 16 clk -> tx sequence per tick: 0,1,1,0,0,0,1,0,1,1. Single frame_done pulse on the 10th tick; baud_en drops on that same edge.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 -> data bits 1,1,1,0,0,0,0,0, parity bit=1, then stop=1. Repeat with PARITY_ODD=1 -> parity bit=0.
- STOP_BITS=2, two bytes 0x55 and 0xAA with tx_valid held high -> second accept coincides with the final stop tick of frame 1. baud_en stays 1 across both frames, tx goes 1→0 directly into the start bit, and frame_done pulses twice.
- Assert rst_n=0 during DATA bit 3 of 0xFF -> tx=1 and baud_en=0 asynchronously. After release, state is IDLE; the next byte 0x01 transmits a full, correct frame.
- tx_data changed mid-frame while busy=1 -> transmitted bits match the originally captured byte; tx_ready stays 0 until the final stop tick.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Brief    : UART transmit sequencer; frames bytes (start/data/parity/stop)
//            on 1x baud ticks and gates the shared baud generator.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 baud_en,
    input  logic                 baud_tick,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam logic [3:0] c_last_data = 4'(DATA_BITS - 1);
    localparam logic       c_last_stop = 1'(STOP_BITS - 1);
    localparam logic       c_par_odd   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [3:0]           r_cnt;
    logic                 r_stop_cnt;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_baud_en;
    logic                 r_busy;
    logic                 r_frame_done;

    logic                 w_last_stop_tick;
    logic                 w_parity;

    assign w_parity         = (^tx_data) ^ c_par_odd;
    assign w_last_stop_tick = (r_state == S_STOP) && baud_tick && (r_stop_cnt == c_last_stop);

    // Ready is combinational so a back-to-back byte can be taken on the very
    // edge that closes the previous frame, keeping the generator running.
    assign tx_ready   = (r_state == S_IDLE) || w_last_stop_tick;
    assign tx         = r_tx;
    assign baud_en    = r_baud_en;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_stop_cnt   <= 1'b0;
            r_parity     <= 1'b0;
            r_tx         <= 1'b1;
            r_baud_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tx_valid) begin
                        r_shift   <= tx_data;
                        r_parity  <= w_parity;
                        r_tx      <= 1'b0;
                        r_baud_en <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_cnt   <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        if (r_cnt == c_last_data) begin
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx       <= 1'b1;
                                r_stop_cnt <= 1'b0;
                                r_state    <= S_STOP;
                            end
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_cnt   <= r_cnt + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_tick) begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_last_stop_tick) begin
                        r_frame_done <= 1'b1;
                        if (tx_valid) begin
                            // baud_en is left asserted to preserve generator phase
                            r_shift  <= tx_data;
                            r_parity <= w_parity;
                            r_tx     <= 1'b0;
                            r_state  <= S_START;
                        end else begin
                            r_baud_en <= 1'b0;
                            r_busy    <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end else if (baud_tick) begin
                        r_stop_cnt <= r_stop_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx      <= 1'b1;
                    r_baud_en <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_ctrl
// Brief    : Directed bench for uart_tx_ctrl in 8N1, 8E1, 8O1 and 8N2 builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       baud_tick = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    logic [3:0] tx_valid  = 4'h0;
    logic [3:0] tx_ready;
    logic [3:0] baud_en;
    logic [3:0] tx;
    logic [3:0] busy;
    logic [3:0] frame_done;

    int checks = 0;
    int errors = 0;
    int fd_cnt [4];

    always #5 clk = ~clk;

    // Instance 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .baud_en(baud_en[0]), .baud_tick(baud_tick),
        .tx(tx[0]), .busy(busy[0]), .frame_done(frame_done[0]));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .baud_en(baud_en[1]), .baud_tick(baud_tick),
        .tx(tx[1]), .busy(busy[1]), .frame_done(frame_done[1]));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .baud_en(baud_en[2]), .baud_tick(baud_tick),
        .tx(tx[2]), .busy(busy[2]), .frame_done(frame_done[2]));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid[3]),
        .tx_ready(tx_ready[3]), .baud_en(baud_en[3]), .baud_tick(baud_tick),
        .tx(tx[3]), .busy(busy[3]), .frame_done(frame_done[3]));

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (frame_done[k] === 1'b1) fd_cnt[k] <= fd_cnt[k] + 1;
        end
    end

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int k, input string tag);
        check({tag, "_tx"}, tx[k], 1'b1);
        check({tag, "_baud_en"}, baud_en[k], 1'b0);
        check({tag, "_busy"}, busy[k], 1'b0);
        check({tag, "_frame_done"}, frame_done[k], 1'b0);
        check({tag, "_tx_ready"}, tx_ready[k], 1'b1);
    endtask

    task automatic accept(input int k, input logic [7:0] data, input logic tick_too);
        tx_data     = data;
        tx_valid[k] = 1'b1;
        baud_tick   = tick_too;
        #1;
        check("accept_ready", tx_ready[k], 1'b1);
        step();
        baud_tick   = 1'b0;
        tx_valid[k] = 1'b0;
        #1;
        check("accept_tx_start", tx[k], 1'b0);
        check("accept_busy", busy[k], 1'b1);
        check("accept_baud_en", baud_en[k], 1'b1);
        check("accept_ready_low", tx_ready[k], 1'b0);
    endtask

    // bits: line value per bit period, first bit in bit position n-1
    task automatic run_frame(input int k, input logic [7:0] data, input logic [11:0] bits,
                             input int n, input logic hold, input logic [7:0] next_data,
                             input logic next_valid);
        int fd0;
        fd0         = fd_cnt[k];
        tx_valid[k] = hold;
        tx_data     = ~data;
        for (int i = 0; i < n; i++) begin
            repeat (15) step();
            baud_tick = 1'b1;
            if (i == n - 1) begin
                tx_data     = next_data;
                tx_valid[k] = next_valid;
            end
            #1;
            check($sformatf("tx_bit%0d", i), tx[k], bits[n-1-i]);
            check($sformatf("baud_en_bit%0d", i), baud_en[k], 1'b1);
            check($sformatf("ready_bit%0d", i), tx_ready[k], (i == n - 1));
            step();
            baud_tick = 1'b0;
        end
        check("frame_done_hi", frame_done[k], 1'b1);
        check("tx_after_frame", tx[k], ~next_valid);
        check("baud_en_after_frame", baud_en[k], next_valid);
        check("busy_after_frame", busy[k], next_valid);
        if (!next_valid) tx_valid[k] = 1'b0;
        step();
        check("frame_done_lo", frame_done[k], 1'b0);
        check_int("frame_done_count", fd_cnt[k] - fd0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int fd_start;

        // Reset and idle behaviour
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_tx", tx[0], 1'b1);
        check("rst_baud_en", baud_en[0], 1'b0);
        check("rst_busy", busy[0], 1'b0);
        check("rst_frame_done", frame_done[0], 1'b0);
        rst_n = 1'b1;
        step();
        check_idle(0, "idle");
        for (int i = 0; i < 3; i++) begin
            baud_tick = 1'b1;
            step();
            baud_tick = 1'b0;
            step();
            check_idle(0, "idle_tick");
        end

        // 8N1 0xA3, accept coincides with an ignored tick
        accept(0, 8'hA3, 1'b1);
        run_frame(0, 8'hA3, 12'b00_0110001011, 10, 1'b0, 8'h00, 1'b0);
        check_idle(0, "post_a3");

        // Even and odd parity, 0x07
        accept(1, 8'h07, 1'b0);
        run_frame(1, 8'h07, 12'b0_01110000011, 11, 1'b0, 8'h00, 1'b0);
        accept(2, 8'h07, 1'b0);
        run_frame(2, 8'h07, 12'b0_01110000001, 11, 1'b0, 8'h00, 1'b0);

        // Two stop bits, back-to-back 0x55 then 0xAA with tx_valid held high
        fd_start = fd_cnt[3];
        accept(3, 8'h55, 1'b0);
        run_frame(3, 8'h55, 12'b0_01010101011, 11, 1'b1, 8'hAA, 1'b1);
        run_frame(3, 8'hAA, 12'b0_00101010111, 11, 1'b1, 8'h00, 1'b0);
        check_int("b2b_frame_done_total", fd_cnt[3] - fd_start, 2);
        check_idle(3, "post_b2b");

        // Asynchronous reset during data bit 3 of 0xFF
        accept(0, 8'hFF, 1'b0);
        tx_data = 8'h00;
        for (int i = 0; i < 4; i++) begin
            repeat (15) step();
            baud_tick = 1'b1;
            step();
            baud_tick = 1'b0;
        end
        repeat (5) step();
        check("pre_rst_busy", busy[0], 1'b1);
        check("pre_rst_tx", tx[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx[0], 1'b1);
        check("async_rst_baud_en", baud_en[0], 1'b0);
        check("async_rst_busy", busy[0], 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check_idle(0, "post_rst");
        baud_tick = 1'b1;
        step();
        baud_tick = 1'b0;
        step();
        check_idle(0, "post_rst_tick");
        accept(0, 8'h01, 1'b0);
        run_frame(0, 8'h01, 12'b00_0100000001, 10, 1'b0, 8'h00, 1'b0);
        check_idle(0, "post_01");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
